// File: rtl/mips_fetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch / PC unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        HOLD    = 3'd2,
        RESOLVE = 3'd3,
        ERROR   = 3'd4
    } fetchState_t;

    typedef enum logic [1:0] {
        SEQ = 2'd0,
        BR  = 2'd1,
        J   = 2'd2,
        JR  = 2'd3
    } nextPcSel_t;

    // Redirect priority: register jump beats direct jump beats taken branch.
    function automatic nextPcSel_t selectNextPc(input logic jumpReg,
                                                input logic jump,
                                                input logic branchCond);
        if (jumpReg)         return JR;
        else if (jump)       return J;
        else if (branchCond) return BR;
        else                 return SEQ;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Purpose: combinational next-PC resolution (sequential, branch, jump, jr).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; outputs only used when the owner commits a resolve.
module next_pc_calc
    import mips_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  jump,
    input  logic                  branchEn,
    input  logic                  branchType,
    input  logic                  jumpReg,
    input  logic                  zero,
    input  logic [DATA_WIDTH-1:0] branchOffset,
    input  logic [25:0]           jumpTarget,
    input  logic [DATA_WIDTH-1:0] regJumpAddr,
    output logic [DATA_WIDTH-1:0] nextPc,
    output logic                  taken,
    output logic                  misaligned
);

    logic [DATA_WIDTH-1:0] pcPlus4;
    logic                  branchCond;
    nextPcSel_t            sel;

    // Pick the redirect source and form its target address.
    always_comb begin
        pcPlus4    = pc + DATA_WIDTH'(4);
        branchCond = branchEn & (branchType ? zero : ~zero);
        sel        = selectNextPc(jumpReg, jump, branchCond);
        nextPc     = pcPlus4;
        taken      = 1'b0;
        misaligned = 1'b0;
        case (sel)
            JR: begin
                nextPc     = regJumpAddr;
                taken      = 1'b1;
                misaligned = |regJumpAddr[1:0];
            end
            J: begin
                nextPc = {pcPlus4[DATA_WIDTH-1:28], jumpTarget, 2'b00};
                taken  = 1'b1;
            end
            BR: begin
                // Offset is in words; the add wraps silently.
                nextPc = pcPlus4 + (branchOffset << 2);
                taken  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Purpose: PC owner and single-outstanding instruction fetch; optional perf counters via FETCH_PERF_CNT_EN.
// Latency: IDLE->FETCH 1 cycle; Instr registered the cycle after ImemReady; PC updates on the resolve edge.
// Backpressure: Instr held in HOLD until InstrAccept; RESOLVE waits for ResolveValid; ERROR is terminal until reset.
module fetch_pc_unit
    import mips_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Jump,
    input  logic                  BranchEn,
    input  logic                  BranchType,
    input  logic                  JumpReg,
    input  logic                  Zero,
    input  logic                  ResolveValid,
    input  logic [DATA_WIDTH-1:0] BranchOffset,
    input  logic [25:0]           JumpTarget,
    input  logic [DATA_WIDTH-1:0] RegJumpAddr,
    output logic                  ImemReq,
    output logic [DATA_WIDTH-1:0] ImemAddr,
    input  logic                  ImemReady,
    input  logic [DATA_WIDTH-1:0] ImemData,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic                  InstrValid,
    input  logic                  InstrAccept,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic                  BranchTaken,
    output logic                  FetchError
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0] FetchCount,
    output logic [DATA_WIDTH-1:0] TakenCount
`endif
);

    fetchState_t           state, nextState;
    logic [7:0]            waitCnt;
    logic                  loadInstr, clrValid, resolveNow, timeout;
    logic [DATA_WIDTH-1:0] nextPc;
    logic                  redirect, misaligned;

    next_pc_calc #(.DATA_WIDTH(DATA_WIDTH)) uNextPc (
        .pc           (PC),
        .jump         (Jump),
        .branchEn     (BranchEn),
        .branchType   (BranchType),
        .jumpReg      (JumpReg),
        .zero         (Zero),
        .branchOffset (BranchOffset),
        .jumpTarget   (JumpTarget),
        .regJumpAddr  (RegJumpAddr),
        .nextPc       (nextPc),
        .taken        (redirect),
        .misaligned   (misaligned)
    );

    assign ImemAddr = PC;
    assign PCPlus4  = PC + DATA_WIDTH'(4);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        nextState  = state;
        ImemReq    = 1'b0;
        loadInstr  = 1'b0;
        clrValid   = 1'b0;
        resolveNow = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: nextState = FETCH;
            FETCH: begin
                ImemReq = 1'b1;
                if (ImemReady) begin
                    loadInstr = 1'b1;
                    nextState = HOLD;
                end else if (waitCnt == 8'(MAX_WAIT - 1)) begin
                    // This is the MAX_WAIT-th consecutive cycle without data.
                    timeout   = 1'b1;
                    nextState = ERROR;
                end
            end
            HOLD: begin
                if (InstrAccept) begin
                    clrValid = 1'b1;
                    if (ResolveValid) begin
                        resolveNow = 1'b1;
                        nextState  = misaligned ? ERROR : FETCH;
                    end else begin
                        nextState = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                if (ResolveValid) begin
                    resolveNow = 1'b1;
                    nextState  = misaligned ? ERROR : FETCH;
                end
            end
            ERROR: ;
            default: nextState = IDLE;
        endcase
    end

    // Datapath registers: PC, instruction latch, wait counter, status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC          <= RESET_PC;
            Instr       <= '0;
            InstrValid  <= 1'b0;
            BranchTaken <= 1'b0;
            FetchError  <= 1'b0;
            waitCnt     <= '0;
        end else begin
            BranchTaken <= 1'b0;
            if (loadInstr) begin
                Instr      <= ImemData;
                InstrValid <= 1'b1;
            end
            if (clrValid) InstrValid <= 1'b0;
            if (state == FETCH && !ImemReady) waitCnt <= waitCnt + 8'd1;
            else                              waitCnt <= '0;
            if (timeout) FetchError <= 1'b1;
            if (resolveNow) begin
                if (misaligned) begin
                    FetchError <= 1'b1;
                end else begin
                    PC          <= nextPc;
                    BranchTaken <= redirect;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counts of completed fetches and redirects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FetchCount <= '0;
            TakenCount <= '0;
        end else begin
            if (loadInstr && FetchCount != '1) FetchCount <= FetchCount + 1'b1;
            if (resolveNow && !misaligned && redirect && TakenCount != '1)
                TakenCount <= TakenCount + 1'b1;
        end
    end
`else
    // Performance counters not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    localparam int          MAXW = 15;
    localparam logic [31:0] RPC  = 32'h0040_0000;
    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_HOLD = 2, PH_RES = 3, PH_ERR = 4;

    logic        clk = 1'b0, reset = 1'b0;
    logic        Jump = 0, BranchEn = 0, BranchType = 0, JumpReg = 0, Zero = 0;
    logic        ResolveValid = 0, ImemReady = 0, InstrAccept = 0;
    logic [31:0] BranchOffset = 0, RegJumpAddr = 0, ImemData = 0;
    logic [25:0] JumpTarget = 0;
    logic        ImemReq, InstrValid, BranchTaken, FetchError;
    logic [31:0] ImemAddr, Instr, PC, PCPlus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, TakenCount;
`endif

    fetch_pc_unit #(.DATA_WIDTH(32), .RESET_PC(RPC), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset), .Jump(Jump), .BranchEn(BranchEn),
        .BranchType(BranchType), .JumpReg(JumpReg), .Zero(Zero),
        .ResolveValid(ResolveValid), .BranchOffset(BranchOffset),
        .JumpTarget(JumpTarget), .RegJumpAddr(RegJumpAddr),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady),
        .ImemData(ImemData), .Instr(Instr), .InstrValid(InstrValid),
        .InstrAccept(InstrAccept), .PC(PC), .PCPlus4(PCPlus4),
        .BranchTaken(BranchTaken), .FetchError(FetchError)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(FetchCount), .TakenCount(TakenCount)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    bit started = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mPhase = PH_IDLE, mWait = 0;
    logic [31:0] mPc = RPC, mInstr = 0;
    bit          mValid = 0, mTaken = 0, mErr = 0;

    // {redirected, target} from the architectural next-PC rules.
    function automatic logic [32:0] modelTarget(input logic [31:0] pc);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (JumpReg)  return {1'b1, RegJumpAddr};
        if (Jump)     return {1'b1, (seq & 32'hF000_0000) | (32'(JumpTarget) * 32'd4)};
        if (BranchEn && (BranchType ? Zero : !Zero))
                      return {1'b1, seq + BranchOffset * 32'd4};
        return {1'b0, seq};
    endfunction

    task automatic modelResolve();
        logic [32:0] r;
        if (JumpReg && RegJumpAddr[1:0] != 2'b00) begin
            mErr   = 1;
            mPhase = PH_ERR;
        end else begin
            r      = modelTarget(mPc);
            mPc    = r[31:0];
            mTaken = r[32];
            mPhase = PH_FETCH;
            mWait  = 0;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPhase = PH_IDLE; mWait = 0; mPc = RPC; mInstr = 0;
            mValid = 0; mTaken = 0; mErr = 0;
        end else begin
            mTaken = 0;
            case (mPhase)
                PH_IDLE: begin mPhase = PH_FETCH; mWait = 0; end
                PH_FETCH: begin
                    if (ImemReady) begin
                        mInstr = ImemData; mValid = 1; mPhase = PH_HOLD;
                    end else begin
                        mWait++;
                        if (mWait >= MAXW) begin mErr = 1; mPhase = PH_ERR; end
                    end
                end
                PH_HOLD: if (InstrAccept) begin
                    mValid = 0;
                    if (ResolveValid) modelResolve();
                    else              mPhase = PH_RES;
                end
                PH_RES: if (ResolveValid) modelResolve();
                default: ;
            endcase
        end
    end

    // Single compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            check("PC",          PC,          mPc);
            check("PCPlus4",     PCPlus4,     mPc + 32'd4);
            check("ImemAddr",    ImemAddr,    mPc);
            check("ImemReq",     32'(ImemReq),     32'(mPhase == PH_FETCH));
            check("Instr",       Instr,       mInstr);
            check("InstrValid",  32'(InstrValid),  32'(mValid));
            check("BranchTaken", 32'(BranchTaken), 32'(mTaken));
            check("FetchError",  32'(FetchError),  32'(mErr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic clearFlags();
        Jump = 0; BranchEn = 0; BranchType = 0; JumpReg = 0; Zero = 0;
        InstrAccept = 0; ResolveValid = 0; ImemReady = 0;
    endtask

    task automatic fetchAndResolve(input logic [31:0] data, input int delay,
                                   input logic jr, input logic j, input logic be,
                                   input logic bt, input logic z,
                                   input logic [31:0] off, input logic [25:0] jt,
                                   input logic [31:0] rja);
        int guard;
        guard = 0;
        clearFlags();
        while (mPhase != PH_FETCH && guard < 50) begin step(); guard++; end
        if (guard >= 50) begin
            vectors++; miscompares++;
            $display("FAIL fetch_wait: no fetch phase within %0d cycles", guard);
        end
        repeat (delay) step();
        ImemReady = 1; ImemData = data;
        step();
        ImemReady = 0;
        JumpReg = jr; Jump = j; BranchEn = be; BranchType = bt; Zero = z;
        BranchOffset = off; JumpTarget = jt; RegJumpAddr = rja;
        InstrAccept = 1; ResolveValid = 1;
        step();
        clearFlags();
    endtask

    initial begin
        #1 reset = 1;
        started = 1;
        #1;
        check("rst_pc", PC, RPC);
        check("rst_instr", Instr, 32'h0);
        check("rst_valid", 32'(InstrValid), 32'h0);
        check("rst_req", 32'(ImemReq), 32'h0);
        check("rst_taken", 32'(BranchTaken), 32'h0);
        check("rst_err", 32'(FetchError), 32'h0);
        @(posedge clk); #2 reset = 0;
        step();
        check("first_req", 32'(ImemReq), 32'h1);
        check("first_addr", ImemAddr, 32'h0040_0000);

        fetchAndResolve(32'h2008_0005, 2, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
        check("seq_pc", PC, 32'h0040_0004);
        check("seq_taken", 32'(BranchTaken), 32'h0);
        check("seq_instr", Instr, 32'h2008_0005);
        check("seq_valid", 32'(InstrValid), 32'h0);
        repeat (3) fetchAndResolve($urandom, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
        check("pc_0x10", PC, 32'h0040_0010);

        fetchAndResolve(32'h1000_FFFD, 1, 0, 0, 1, 1, 1, 32'hFFFF_FFFD, 26'h0, 32'h0);
        check("beq_pc", PC, 32'h0040_0008);
        check("beq_taken", 32'(BranchTaken), 32'h1);
        step();
        check("beq_pulse_end", 32'(BranchTaken), 32'h0);
        repeat (2) fetchAndResolve($urandom, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
        fetchAndResolve(32'h1400_FFFD, 0, 0, 0, 1, 0, 1, 32'hFFFF_FFFD, 26'h0, 32'h0);
        check("bne_pc", PC, 32'h0040_0014);
        check("bne_taken", 32'(BranchTaken), 32'h0);

        fetchAndResolve(32'h0810_0008, 0, 0, 1, 1, 1, 1, 32'h3, 26'h010_0008, 32'h0);
        check("jump_pc", PC, 32'h0040_0020);
        check("jump_taken", 32'(BranchTaken), 32'h1);

        // Hold decode off for 5 cycles with a stray ResolveValid.
        step();
        ImemReady = 1; ImemData = 32'hDEAD_BEEF;
        step();
        ImemReady = 0;
        for (int i = 0; i < 5; i++) begin
            ResolveValid = (i == 2); Jump = (i == 2); JumpTarget = 26'h3FF_FFFF;
            step();
            check("hold_instr", Instr, 32'hDEAD_BEEF);
            check("hold_valid", 32'(InstrValid), 32'h1);
            check("hold_pc", PC, 32'h0040_0020);
        end
        clearFlags();
        InstrAccept = 1; ResolveValid = 1;
        step();
        clearFlags();
        check("hold_release_pc", PC, 32'h0040_0024);

        fetchAndResolve(32'h0080_0008, 0, 1, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0040_0102);
        check("jr_mis_pc", PC, 32'h0040_0024);
        check("jr_mis_err", 32'(FetchError), 32'h1);
        check("jr_mis_taken", 32'(BranchTaken), 32'h0);
        ImemReady = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("err_req", 32'(ImemReq), 32'h0);
        end
        ImemReady = 0;

        // Fetch timeout.
        doReset();
        step();
        check("to_req", 32'(ImemReq), 32'h1);
        for (int i = 0; i < MAXW - 1; i++) begin
            step();
            check("to_err_early", 32'(FetchError), 32'h0);
        end
        step();
        check("to_err", 32'(FetchError), 32'h1);
        check("to_req_off", 32'(ImemReq), 32'h0);

        // Reset in the middle of a fetch.
        doReset();
        fetchAndResolve($urandom, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
        repeat (2) step();
        reset = 1;
        #1;
        check("midrst_pc", PC, 32'h0040_0000);
        check("midrst_valid", 32'(InstrValid), 32'h0);
        check("midrst_req", 32'(ImemReq), 32'h0);
        step();
        reset = 0;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] o;
            if ((mPhase == PH_ERR && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) begin
                doReset();
            end else begin
                o            = 8'($urandom);
                ImemReady    = ($urandom_range(0, 3) != 0);
                ImemData     = $urandom;
                InstrAccept  = $urandom_range(0, 1) != 0;
                ResolveValid = $urandom_range(0, 1) != 0;
                Jump         = ($urandom_range(0, 3) == 0);
                BranchEn     = $urandom_range(0, 1) != 0;
                BranchType   = $urandom_range(0, 1) != 0;
                Zero         = $urandom_range(0, 1) != 0;
                JumpReg      = ($urandom_range(0, 5) == 0);
                RegJumpAddr  = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
                BranchOffset = {{24{o[7]}}, o};
                JumpTarget   = 26'($urandom);
                step();
            end
        end
        clearFlags();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Owns the program counter and the instruction-fetch handshake with instruction memory.
- Presents the fetched instruction to decode. Decode drives the opcode into the control unit.
- Consumes that unit's Jump/BranchEn/BranchType outputs plus the ALU Zero flag to resolve the next PC.
- Multicycle operation: one instruction is in flight at a time.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction word
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- MAX_WAIT, 15, maximum cycles in FETCH without ImemReady before timeout (1..255)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Jump  in  1  from control unit; J/JAL
- BranchEn  in  1  from control unit; conditional branch
- BranchType  in  1  from control unit; 1 = beq, 0 = bne
- JumpReg  in  1  from ALU control; jr
- Zero  in  1  ALU zero flag
- ResolveValid  in  1  control/ALU inputs valid for the current instruction
- BranchOffset  in  DATA_WIDTH  sign-extended immediate, in words
- JumpTarget  in  26  instr[25:0]
- RegJumpAddr  in  DATA_WIDTH  rs value for jr
- ImemReq  out  1  fetch request
- ImemAddr  out  DATA_WIDTH  fetch address (= PC)
- ImemReady  in  1  memory returns data this cycle
- ImemData  in  DATA_WIDTH  instruction word
- Instr  out  DATA_WIDTH  registered instruction
- InstrValid  out  1  Instr valid for decode
- InstrAccept  in  1  decode consumes Instr
- PC  out  DATA_WIDTH  current PC
- PCPlus4  out  DATA_WIDTH  PC+4, used as the JAL link value
- BranchTaken  out  1  one-cycle pulse when a branch or jump redirects the PC
- FetchError  out  1  sticky: timeout or misaligned target

Behaviour:
- Reset: PC = RESET_PC, Instr = 0, InstrValid = 0, ImemReq = 0, BranchTaken = 0, FetchError = 0, wait counter = 0, state = IDLE.
- IDLE: unconditionally moves to FETCH on the next cycle.
- FETCH: ImemReq = 1 and ImemAddr = PC.
  - On ImemReady, Instr <= ImemData, InstrValid <= 1, and the state moves to HOLD. ImemReq drops the cycle after ImemReady.
  - The wait counter increments each non-ready cycle. When it reaches MAX_WAIT, FetchError <= 1 and the state moves to ERROR.
- HOLD: InstrValid stays 1 and Instr stays stable until InstrAccept.
  - InstrAccept with ResolveValid in the same cycle: resolve immediately and go to FETCH.
  - InstrAccept alone: InstrValid <= 0 and the state moves to RESOLVE.
- RESOLVE: waits for ResolveValid, then updates the PC and moves to FETCH. The wait counter clears.
- Next-PC priority, evaluated at resolve: JumpReg > Jump > taken branch > sequential.
  - JumpReg: PC <= RegJumpAddr.
  - Jump: PC <= {PCPlus4[31:28], JumpTarget, 2'b00}.
  - Branch taken when BranchEn & (BranchType ? Zero : ~Zero). Target: PC <= PCPlus4 + (BranchOffset << 2); wraps modulo 2^32 with no overflow flag.
  - Otherwise: PC <= PCPlus4.
- BranchTaken pulses for one cycle, coincident with the PC update, for any non-sequential redirect.
- Misaligned target (jr with RegJumpAddr[1:0] != 0): the PC is not updated, FetchError <= 1, and the state moves to ERROR.
- ERROR: all outputs hold and ImemReq = 0. Only reset exits this state.
- PCPlus4 is always PC + 4, combinational.
- ResolveValid outside HOLD and RESOLVE is ignored. ImemReady outside FETCH is ignored.
- Reset asserted mid-fetch: the handshake is abandoned and all state returns to reset values on the same edge.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two output ports, each DATA_WIDTH wide:
  - FetchCount: increments on each ImemReady accepted in FETCH.
  - TakenCount: increments on each BranchTaken pulse.
  - Both reset to 0 and saturate at all-ones.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package mips_fetch_pkg holds:
  - the state encoding (IDLE, FETCH, HOLD, RESOLVE, ERROR)
  - the default RESET_PC constant
  - the next-PC select encoding (SEQ, BR, J, JR)
- One combinational sub-module, next_pc_calc. Inputs: PC, control flags, offset, targets. Outputs: next PC, taken, misaligned.
- The FSM and registers stay in fetch_pc_unit.

Test Plan:
- Reset, then ImemReady after 2 cycles with ImemData = 32'h2008_0005; accept with ResolveValid and all flags 0 → ImemAddr = 32'h0040_0000, then PC = 32'h0040_0004, BranchTaken = 0.
- PC = 32'h0040_0010, BranchEn = 1, BranchType = 1, Zero = 1, BranchOffset = 32'hFFFF_FFFD → PC = 32'h0040_0008 and BranchTaken pulses. Same inputs with BranchType = 0 → PC = 32'h0040_0014.
- Jump = 1 and BranchEn = 1 together, JumpTarget = 26'h010_0008 → jump wins, PC = 32'h0040_0020.
- JumpReg = 1, RegJumpAddr = 32'h0040_0102 → PC unchanged, FetchError = 1, ImemReq stays 0 thereafter until reset.
- ImemReady held low for MAX_WAIT = 15 cycles → FetchError = 1 in cycle 15, state ERROR. Reset asserted mid-fetch → PC = 32'h0040_0000, InstrValid = 0.
- InstrAccept held low for 5 cycles after the fetch → Instr and InstrValid stable; a ResolveValid pulse during HOLD without accept leaves the PC unchanged.
